dmem_access: RTL and testbench

Data-memory access unit for the RV64 core. It sits directly downstream of the control block and consumes `rd_mem_addr` and the load/store opcode. It runs one transaction on a 64-bit doubleword data bus with a valid/ready handshake, stalling the core until the transaction completes. It returns the addressed bytes right-justified on `mem_rd_data`; sign or zero extension stays in the control block.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 66 ++++++
 rtl/dmem_access.sv | 130 +++++++++++++
 tb/tb_dmem_access.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the RV64 data-memory access path.
//   - bit positions of the one-hot load/store opcode vectors
//   - byte-lane size masks
//   - state encoding of the dmem_access FSM
package riscv_pkg;
  // rd_mem_op bit positions
  localparam int LD  = 0;
  localparam int LW  = 1;
  localparam int LH  = 2;
  localparam int LB  = 3;
  localparam int LWU = 4;
  localparam int LHU = 5;
  localparam int LBU = 6;
  // wr_mem_op bit positions
  localparam int SD  = 0;
  localparam int SW  = 1;
  localparam int SH  = 2;
  localparam int SB  = 3;

  localparam logic [7:0] MASK_D = 8'hFF;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_B = 8'h01;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} dmem_state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for dmem_access.
// Optional feature macro: DMEM_MISALIGN_EXC_EN (enables misalign detect;
// when undefined o_misalign is constant 0).
// Ports:
//   i_rd_op / i_wr_op  one-hot load / store opcodes (load wins)
//   i_off              byte offset inside the doubleword (addr[2:0])
//   i_wr_data          right-justified store data
//   i_rsp_off/i_rsp_mask  offset and size mask captured for the response
//   i_rdata            read doubleword from the bus
//   o_is_load          access is a load
//   o_mask             size mask of the access
//   o_wstrb / o_wdata  lane-shifted strobes / data (0 for loads)
//   o_rd_bytes         addressed bytes right-justified, upper bytes zero
//   o_misalign         offset not a multiple of the access size
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [6:0]  i_rd_op,
  input  logic [3:0]  i_wr_op,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_wr_data,
  input  logic [2:0]  i_rsp_off,
  input  logic [7:0]  i_rsp_mask,
  input  logic [63:0] i_rdata,
  output logic        o_is_load,
  output logic [7:0]  o_mask,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rd_bytes,
  output logic        o_misalign
);
  logic [63:0] w_shr;

  always_comb begin
    o_is_load = |i_rd_op;
    o_mask    = MASK_B;
    if (o_is_load) begin
      if (i_rd_op[LD])                     o_mask = MASK_D;
      else if (i_rd_op[LW] | i_rd_op[LWU]) o_mask = MASK_W;
      else if (i_rd_op[LH] | i_rd_op[LHU]) o_mask = MASK_H;
    end else begin
      if (i_wr_op[SD])      o_mask = MASK_D;
      else if (i_wr_op[SW]) o_mask = MASK_W;
      else if (i_wr_op[SH]) o_mask = MASK_H;
    end
  end

  // 8-bit result truncates lanes that run past byte 7
  assign o_wstrb = o_is_load ? 8'h00 : (o_mask << i_off);
  assign o_wdata = o_is_load ? 64'h0 : (i_wr_data << {i_off, 3'b000});

  assign w_shr = i_rdata >> {i_rsp_off, 3'b000};
  always_comb begin
    o_rd_bytes = '0;
    for (int b = 0; b < 8; b++)
      o_rd_bytes[8*b +: 8] = w_shr[8*b +: 8] & {8{i_rsp_mask[b]}};
  end

`ifdef DMEM_MISALIGN_EXC_EN
  assign o_misalign = ((o_mask == MASK_D) && (i_off != 3'd0))      ||
                      ((o_mask == MASK_W) && (i_off[1:0] != 2'd0)) ||
                      ((o_mask == MASK_H) && i_off[0]);
`else
  assign o_misalign = 1'b0;
`endif
endmodule

// File: rtl/dmem_access.sv
// dmem_access: one load/store transaction on a 64-bit valid/ready data bus,
// stalling the core until it completes. Loaded bytes come back right-justified.
// Optional feature macro: DMEM_MISALIGN_EXC_EN (misaligned accesses skip the
// bus and pulse mem_misalign in DONE).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_mem_op, wr_mem_op     one-hot load/store opcodes
//   mem_addr, mem_wr_data    effective address, store data
//   mem_rd_data              loaded bytes
//   mem_stall, mem_misalign  core stall, misalign pulse
//   dbus_*                   data-bus request/response
module dmem_access
  import riscv_pkg::*;
#(
  parameter int BUS_AW = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        rd_mem_op,
  input  logic [3:0]        wr_mem_op,
  input  logic [63:0]       mem_addr,
  input  logic [63:0]       mem_wr_data,
  output logic [63:0]       mem_rd_data,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic [BUS_AW-1:0] dbus_addr,
  output logic              dbus_we,
  output logic [63:0]       dbus_wdata,
  output logic [7:0]        dbus_wstrb,
  input  logic              dbus_rsp_valid,
  input  logic [63:0]       dbus_rdata
);
  dmem_state_e       r_state;
  logic              r_req_valid, r_we, r_misalign, r_is_load;
  logic [BUS_AW-1:0] r_addr;
  logic [63:0]       r_wdata, r_rd_data;
  logic [7:0]        r_wstrb, r_rmask;
  logic [2:0]        r_off;

  logic              w_op_any, w_is_load, w_misalign;
  logic [7:0]        w_mask, w_wstrb;
  logic [63:0]       w_wdata, w_rd_bytes;

  assign w_op_any = (|rd_mem_op) | (|wr_mem_op);

  dmem_lane_align u_align (
    .i_rd_op    (rd_mem_op),
    .i_wr_op    (wr_mem_op),
    .i_off      (mem_addr[2:0]),
    .i_wr_data  (mem_wr_data),
    .i_rsp_off  (r_off),
    .i_rsp_mask (r_rmask),
    .i_rdata    (dbus_rdata),
    .o_is_load  (w_is_load),
    .o_mask     (w_mask),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rd_bytes (w_rd_bytes),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_we        <= 1'b0;
      r_wstrb     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_data   <= '0;
      r_misalign  <= 1'b0;
      r_is_load   <= 1'b0;
      r_off       <= '0;
      r_rmask     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_misalign <= 1'b0;
          if (w_op_any) begin
            // offset/size kept so the response is steered without re-sampling
            r_off     <= mem_addr[2:0];
            r_rmask   <= w_mask;
            r_is_load <= w_is_load;
            if (w_misalign) begin
              r_state    <= ST_DONE;
              r_misalign <= 1'b1;
              r_rd_data  <= '0;
            end else begin
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
              r_addr      <= {mem_addr[BUS_AW-1:3], 3'b000};
              r_we        <= ~w_is_load;
              r_wdata     <= w_wdata;
              r_wstrb     <= w_wstrb;
            end
          end
        end
        ST_REQ: begin
          if (dbus_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (dbus_rsp_valid) begin
            r_rd_data <= r_is_load ? w_rd_bytes : 64'h0;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_misalign <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_stall = ~rst & (((r_state == ST_IDLE) & w_op_any) |
                             (r_state == ST_REQ) | (r_state == ST_RESP));

  assign mem_rd_data    = r_rd_data;
  assign mem_misalign   = r_misalign;
  assign dbus_req_valid = r_req_valid;
  assign dbus_addr      = r_addr;
  assign dbus_we        = r_we;
  assign dbus_wdata     = r_wdata;
  assign dbus_wstrb     = r_wstrb;
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: randomized + directed bench for dmem_access with a
// scoreboard. Bus requests and completions are predicted by a byte-level
// reference model and checked by independent monitor processes.
module tb_dmem_access;
`ifdef DMEM_MISALIGN_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  rd_mem_op;
  logic [3:0]  wr_mem_op;
  logic [63:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_stall, mem_misalign;
  logic        dbus_req_valid, dbus_req_ready, dbus_we, dbus_rsp_valid;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]  dbus_wstrb;

  always #5 clk = ~clk;

  dmem_access #(.BUS_AW(64)) dut (
    .clk(clk), .rst(rst), .rd_mem_op(rd_mem_op), .wr_mem_op(wr_mem_op),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb), .dbus_rsp_valid(dbus_rsp_valid),
    .dbus_rdata(dbus_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct { logic [63:0] addr; logic we; logic [7:0] strb; logic [63:0] wdata; } req_t;
  typedef struct { logic [63:0] rd; logic mis; } done_t;
  req_t  req_q[$];
  done_t done_q[$];

  // responder settings for the transaction in flight
  int          rsp_rdy_dly = 0;
  int          rsp_rsp_dly = 0;
  logic [63:0] rsp_data    = '0;

  // Reference model: byte-by-byte view of the access.
  task automatic model(input logic [6:0] rop, input logic [3:0] wop, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rdat,
                       output req_t rq, output done_t dn, output bit mis);
    int sz, off;
    bit ld;
    ld  = (rop != 0);
    off = int'(addr[2:0]);
    if (ld) sz = rop[0] ? 8 : (rop[1] | rop[4]) ? 4 : (rop[2] | rop[5]) ? 2 : 1;
    else    sz = wop[0] ? 8 : wop[1] ? 4 : wop[2] ? 2 : 1;
    mis      = EXC && ((off % sz) != 0);
    rq.addr  = addr - 64'(off);
    rq.we    = !ld;
    rq.strb  = '0;
    rq.wdata = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off) begin
        if (!ld && (i - off) < sz) rq.strb[i] = 1'b1;
        rq.wdata[8*i +: 8] = wd[8*(i-off) +: 8];
      end
    dn.mis = mis;
    dn.rd  = '0;
    if (ld && !mis)
      for (int i = 0; i < sz; i++)
        if (off + i < 8) dn.rd[8*i +: 8] = rdat[8*(off+i) +: 8];
  endtask

  // Called at posedge+#1 with the DUT idle; returns at posedge+#1 after DONE.
  task automatic run_txn(input logic [6:0] rop, input logic [3:0] wop, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rdat, input int rdy, input int rsp);
    req_t rq; done_t dn; bit mis;
    int stalls, exp_st;
    model(rop, wop, addr, wd, rdat, rq, dn, mis);
    if (!mis) req_q.push_back(rq);
    done_q.push_back(dn);
    rsp_rdy_dly = rdy; rsp_rsp_dly = rsp; rsp_data = rdat;
    rd_mem_op = rop; wr_mem_op = wop; mem_addr = addr; mem_wr_data = wd;
    exp_st = mis ? 1 : 3 + rdy + rsp;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      if (stalls > 200) begin
        chk("stall_timeout", 64'(stalls), 64'(exp_st));
        break;
      end
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_st));
    @(posedge clk); #1;
    rd_mem_op = '0; wr_mem_op = '0;
  endtask

  // Bus responder: ready after rsp_rdy_dly cycles, response rsp_rsp_dly cycles later.
  initial begin
    dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dbus_req_valid) begin
        repeat (rsp_rdy_dly) begin @(posedge clk); #1; end
        dbus_req_ready = 1'b1;
        @(posedge clk); #1;
        dbus_req_ready = 1'b0;
        repeat (rsp_rsp_dly) begin @(posedge clk); #1; end
        dbus_rsp_valid = 1'b1; dbus_rdata = rsp_data;
        @(posedge clk); #1;
        dbus_rsp_valid = 1'b0; dbus_rdata = $urandom();
      end
    end
  end

  // Request monitor: every valid cycle must match the head entry (checks stability).
  initial begin
    req_t f;
    forever begin
      @(negedge clk);
      if (!rst && dbus_req_valid) begin
        if (req_q.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
        else begin
          f = req_q[0];
          chk("req_addr", dbus_addr, f.addr);
          chk("req_we", 64'(dbus_we), 64'(f.we));
          chk("req_wstrb", 64'(dbus_wstrb), 64'(f.strb));
          if (f.we) chk("req_wdata", dbus_wdata, f.wdata);
          if (dbus_req_ready) void'(req_q.pop_front());
        end
      end
    end
  end

  // Completion monitor: DONE is the cycle where an op is presented but stall is low.
  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst && ((|rd_mem_op) || (|wr_mem_op)) && !mem_stall) begin
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          d = done_q.pop_front();
          chk("done_rd_data", mem_rd_data, d.rd);
          chk("done_misalign", 64'(mem_misalign), 64'(d.mis));
        end
      end else if (!rst) begin
        chk("misalign_idle", 64'(mem_misalign), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    req_t rq; done_t dn; bit mis;
    logic [6:0] rop; logic [3:0] wop; int kind;
    rst = 1'b1; rd_mem_op = 7'h01; wr_mem_op = '0; mem_addr = 64'h1000; mem_wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_req_valid", 64'(dbus_req_valid), 64'd0);
    chk("rst_we", 64'(dbus_we), 64'd0);
    chk("rst_wstrb", 64'(dbus_wstrb), 64'd0);
    chk("rst_addr", dbus_addr, 64'd0);
    chk("rst_wdata", dbus_wdata, 64'd0);
    chk("rst_rd_data", mem_rd_data, 64'd0);
    chk("rst_misalign", 64'(mem_misalign), 64'd0);
    rd_mem_op = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    run_txn(7'h01, 4'h0, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0);
    chk("ld_rd_data", mem_rd_data, 64'h1122334455667788);
    chk("ld_addr", dbus_addr, 64'h1000);
    run_txn(7'h08, 4'h0, 64'h1005, 64'h0, 64'h1122334455667788, 0, 0);
    chk("lb_rd_data", mem_rd_data, 64'h33);
    chk("lb_wstrb", 64'(dbus_wstrb), 64'h0);
    run_txn(7'h00, 4'h4, 64'h2002, 64'hBEEF, 64'h0, 0, 0);
    chk("sh_wstrb", 64'(dbus_wstrb), 64'h0C);
    chk("sh_wdata", 64'(dbus_wdata[31:16]), 64'hBEEF);
    chk("sh_we", 64'(dbus_we), 64'd1);
    run_txn(7'h00, 4'h1, 64'h2400, 64'hCAFEF00D12345678, 64'h0, 4, 0);
    run_txn(7'h02, 4'h0, 64'h3002, 64'h0, 64'h1122334455667788, 0, 1);
    chk("lw_mis_rd_data", mem_rd_data, EXC ? 64'h0 : 64'h33445566);
    // load and store together: load wins
    run_txn(7'h20, 4'h1, 64'h4006, 64'hFFFF, 64'hA1B2C3D4E5F60718, 1, 2);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      rop  = (kind != 1) ? 7'(1 << $urandom_range(0, 6)) : 7'h0;
      wop  = (kind != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      run_txn(rop, wop, {$urandom(), $urandom()}, {$urandom(), $urandom()},
              {$urandom(), $urandom()}, $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    // reset while in RESP, late response afterwards must be ignored
    run_txn(7'h01, 4'h0, 64'h5000, 64'h0, 64'hDEADBEEF00000000, 0, 0); // mem_rd_data nonzero
    model(7'h01, 4'h0, 64'h5008, 64'h0, 64'h0123456789ABCDEF, rq, dn, mis);
    req_q.push_back(rq);
    rsp_rdy_dly = 0; rsp_rsp_dly = 3; rsp_data = 64'h0123456789ABCDEF;
    rd_mem_op = 7'h01; mem_addr = 64'h5008;
    @(posedge clk); #1;             // REQ, accepted this cycle
    @(posedge clk); #1;             // RESP
    rst = 1'b1; rd_mem_op = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_stall", 64'(mem_stall), 64'd0);
    chk("rstmid_req_valid", 64'(dbus_req_valid), 64'd0);
    repeat (5) @(negedge clk);
    chk("rstmid_rd_data", mem_rd_data, 64'd0);
    chk("rstmid_stall_late", 64'(mem_stall), 64'd0);

    repeat (5) @(posedge clk);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
